// File: rtl/atualizador_tiros.sv
// atualizador_tiros: sweeps 16 shot slots, moves each shot one step, drops edge crossers, inserts a pending shot
// Ports: clk/reset (sync, active-high); iniciar starts a sweep; novo_tiro/tiro_in queue a shot for the next sweep;
// mem_addr/mem_we/mem_data/mem_q drive a registered-address shot memory; ocupado busy; pronto/cheio end-of-sweep
// pulses; qtd_tiros holds the active-shot count of the last completed sweep.
module atualizador_tiros (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       novo_tiro,
    input  logic [9:0] tiro_in,
    output logic [3:0] mem_addr,
    output logic       mem_we,
    output logic [9:0] mem_data,
    input  logic [9:0] mem_q,
    output logic       ocupado,
    output logic       pronto,
    output logic       cheio,
    output logic [4:0] qtd_tiros
);
    typedef enum logic [2:0] {OCIOSO, ENDERECA, LE, ESCREVE, FIM} estado_t;
    estado_t estado, prox;
    logic [3:0] idx;
    logic       pend;
    logic [9:0] tiro, palavra, movido;
    logic [4:0] cnt;
    logic [3:0] x, y;
    assign x = mem_q[9:6];
    assign y = mem_q[5:2];
    always_ff @(posedge clk)
        if (reset) estado <= OCIOSO;
        else       estado <= prox;
    always_comb begin
        prox     = estado;
        mem_addr = idx;
        mem_we   = estado == ESCREVE;
        mem_data = palavra;
        ocupado  = estado != OCIOSO;
        pronto   = estado == FIM;
        cheio    = estado == FIM && pend;
        case (estado)
            OCIOSO:   prox = iniciar ? ENDERECA : OCIOSO;
            ENDERECA: prox = LE;
            LE:       prox = ESCREVE;
            ESCREVE:  prox = idx == 4'd15 ? FIM : ENDERECA;
            default:  prox = OCIOSO;
        endcase
    end
    // Moves past the grid edge yield 0, which removes the shot.
    always_comb begin
        movido = 10'b0;
        if (mem_q != 10'b0)
            case (mem_q[1:0])
                2'b00:   movido = y == 4'd0  ? 10'b0 : {x, y - 4'd1, 2'b00};
                2'b01:   movido = y == 4'd15 ? 10'b0 : {x, y + 4'd1, 2'b01};
                2'b10:   movido = x == 4'd0  ? 10'b0 : {x - 4'd1, y, 2'b10};
                default: movido = x == 4'd15 ? 10'b0 : {x + 4'd1, y, 2'b11};
            endcase
    end
    always_ff @(posedge clk)
        if (reset) begin
            idx       <= 4'd0;
            pend      <= 1'b0;
            tiro      <= 10'b0;
            palavra   <= 10'b0;
            cnt       <= 5'd0;
            qtd_tiros <= 5'd0;
        end else
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        idx <= 4'd0;
                        cnt <= 5'd0;
                    end
                    if (novo_tiro && tiro_in != 10'b0) begin
                        pend <= 1'b1;
                        tiro <= tiro_in;
                    end
                end
                LE: begin
                    palavra <= pend && movido == 10'b0 ? tiro : movido;
                    if (pend && movido == 10'b0) pend <= 1'b0;
                end
                ESCREVE: begin
                    idx <= idx + 4'd1;
                    cnt <= cnt + {4'd0, palavra != 10'b0};
                end
                FIM: begin
                    pend      <= 1'b0;
                    qtd_tiros <= cnt;
                end
                default: ;
            endcase
endmodule

// File: doc/atualizador_tiros.md
ATUALIZADOR_TIROS -- requirements
Module: atualizador_tiros

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 iniciar  input  1  one-cycle request to sweep all 16 shot slots.
REQ-004 novo_tiro  input  1  one-cycle request to insert tiro_in during the next sweep.
REQ-005 tiro_in  input  10  new shot word: [9:6]=x, [5:2]=y, [1:0]=direction.
REQ-006 mem_addr  output  4  shot-memory address (memory registers address; mem_q valid the cycle after).
REQ-007 mem_we  output  1  shot-memory write enable.
REQ-008 mem_data  output  10  shot-memory write data.
REQ-009 mem_q  input  10  shot-memory read data.
REQ-010 ocupado  output  1  high whenever FSM is not OCIOSO.
REQ-011 pronto  output  1  one-cycle pulse at sweep end.
REQ-012 cheio  output  1  one-cycle pulse with pronto when a pending shot found no free slot.
REQ-013 qtd_tiros  output  5  count of nonzero words written in the last completed sweep (0..16).

Function
REQ-014 Word 10'b0 SHALL mean empty slot; any nonzero word is an active shot.
REQ-015 Directions SHALL be 00=up (y-1), 01=down (y+1), 10=left (x-1), 11=right (x+1), one unit per sweep.
REQ-016 A move crossing the 16x16 grid edge (y=0 up, y=15 down, x=0 left, x=15 right) SHALL write 10'b0 (shot removed), never wrap.
REQ-017 Empty slots SHALL be rewritten as 10'b0.
REQ-018 FSM states SHALL be OCIOSO, ENDERECA, LE, ESCREVE, FIM; slot index idx 4 bits.
REQ-019 OCIOSO: iniciar=1 sampled -> idx=0, go ENDERECA; iniciar ignored in all other states.
REQ-020 ENDERECA: mem_addr=idx, mem_we=0; go LE.
REQ-021 LE: mem_q valid; compute and register new word per REQ-015..017/REQ-023; go ESCREVE.
REQ-022 ESCREVE: mem_addr=idx, mem_we=1, mem_data=registered word; idx=15 -> FIM, else idx+1 -> ENDERECA.
REQ-023 Pending shot: first slot whose computed word is 10'b0 SHALL receive tiro_in instead (not moved this sweep); pending then cleared.
REQ-024 novo_tiro SHALL be sampled only in OCIOSO; tiro_in captured then; tiro_in=0 ignored; second request before the sweep overwrites the first.
REQ-025 FIM: pronto=1 one cycle; cheio=1 if pending still set; pending cleared; qtd_tiros updated; go OCIOSO.
REQ-026 Sweep timing: iniciar sampled at edge E -> 3 cycles per slot, pronto high in cycle E+49; ocupado high cycles E+1..E+49.
REQ-027 mem_we SHALL be 0 in every state except ESCREVE; mem_addr=idx in all states.
REQ-028 qtd_tiros SHALL hold its value between sweeps.

Reset
REQ-029 reset=1 SHALL force OCIOSO, idx=0, pending=0, mem_we=0, mem_data=0, pronto=0, cheio=0, qtd_tiros=0, ocupado=0 at the next edge.
REQ-030 reset mid-sweep SHALL abort with no further writes; already-written slots stay updated (no rollback).
REQ-031 reset SHALL have priority over iniciar and novo_tiro in the same cycle.

Verification
REQ-032 Slot 0=0111_0101_00, slot 12=0001_0111_00, others 0; iniciar -> slot 0=0111_0100_00, slot 12=0001_0110_00, qtd_tiros=2, pronto at E+49.
REQ-033 Slots 0..3 = 0111_0000_00, 0000_0101_10, 1111_0011_11, 0100_1111_01 -> all four written 0, qtd_tiros=0, cheio=0.
REQ-034 All slots active mid-grid, novo_tiro with tiro_in=0011_0011_01 plus iniciar -> all moved, cheio=1 with pronto, qtd_tiros=16.
REQ-035 Slots 0,1 active, rest 0, novo_tiro tiro_in=1000_1000_11 -> slot 2=1000_1000_11 unmoved, qtd_tiros=3, cheio=0.
REQ-036 reset asserted at E+10 -> ocupado=0 next edge, no mem_we afterwards, slots 0..2 updated, slots 3..15 unchanged; iniciar during busy ignored.
